// File: rtl/axil_rw_arbiter.sv
// Two-requester arbiter/sequencer sharing one AXI-lite master wrapper between
// instruction fetch (read-only) and load/store (read, write or null request).
// Only one transaction is outstanding at a time. MEM has priority over IF,
// but a streak counter forces an IF grant after MEM_STREAK_MAX consecutive
// MEM grants taken while IF was waiting.
module axil_rw_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,

    // Instruction fetch requester
    input  logic                  i_if_valid,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_addr_ok,
    output logic                  o_if_data_ok,
    output logic [DATA_WIDTH-1:0] o_if_rdata,

    // Load/store requester
    input  logic                  i_mem_valid,
    input  logic                  i_mem_ren,
    input  logic                  i_mem_wen,
    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    input  logic [STRB_WIDTH-1:0] i_mem_wstrb,
    output logic                  o_mem_addr_ok,
    output logic                  o_mem_data_ok,
    output logic [DATA_WIDTH-1:0] o_mem_rdata,

    // Request interface of the AXI-lite master wrapper
    output logic                  o_m_valid,
    output logic                  o_m_ren,
    output logic                  o_m_wen,
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    output logic [STRB_WIDTH-1:0] o_m_wstrb,
    input  logic                  i_m_addr_ok,
    input  logic                  i_m_data_ok,
    input  logic [DATA_WIDTH-1:0] i_m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [2:0] STREAK_MAX = 3'(MEM_STREAK_MAX);

    state_e                state_q,    state_d;
    logic [2:0]            streak_q,   streak_d;
    logic                  ownerMem_q, ownerMem_d;
    logic                  mRen_q,     mRen_d;
    logic                  mWen_q,     mWen_d;
    logic [ADDR_WIDTH-1:0] mAddr_q,    mAddr_d;
    logic [DATA_WIDTH-1:0] mWdata_q,   mWdata_d;
    logic [STRB_WIDTH-1:0] mWstrb_q,   mWstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;

    logic memGrant;
    logic ifGrant;
    logic memIsRead;
    logic memIsNull;
    logic ifForced;

    // The wrapper only reports completion; address acceptance carries no
    // extra information for this sequencer.
    logic unusedAddrOk;
    assign unusedAddrOk = i_m_addr_ok;

    // Arbitration: MEM wins in IDLE unless IF has been starved long enough.
    always_comb begin
        ifForced  = i_if_valid && (streak_q == STREAK_MAX);
        memGrant  = (state_q == ST_IDLE) && i_mem_valid && !ifForced;
        ifGrant   = (state_q == ST_IDLE) && i_if_valid && !memGrant;
        memIsRead = !i_mem_wen && i_mem_ren;
        memIsNull = !i_mem_wen && !i_mem_ren;
    end

    // Next-state logic: latch the winner on a grant, sequence the transfer,
    // capture read data on completion.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        ownerMem_d = ownerMem_q;
        mRen_d     = mRen_q;
        mWen_d     = mWen_q;
        mAddr_d    = mAddr_q;
        mWdata_d   = mWdata_q;
        mWstrb_d   = mWstrb_q;
        rdata_d    = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (memGrant) begin
                    ownerMem_d = 1'b1;
                    mAddr_d    = i_mem_addr;
                    mWdata_d   = i_mem_wdata;
                    mWstrb_d   = i_mem_wstrb;
                    mWen_d     = i_mem_wen;
                    mRen_d     = memIsRead;
                    rdata_d    = '0;
                    if (i_if_valid) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 3'd1;
                    end else begin
                        streak_d = 3'd0;
                    end
                    state_d = memIsNull ? ST_RESP : ST_ISSUE;
                end else if (ifGrant) begin
                    ownerMem_d = 1'b0;
                    mAddr_d    = i_if_addr;
                    mWdata_d   = '0;
                    mWstrb_d   = '0;
                    mWen_d     = 1'b0;
                    mRen_d     = 1'b1;
                    rdata_d    = '0;
                    streak_d   = 3'd0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_m_data_ok) begin
                    rdata_d = mRen_q ? i_m_rdata : '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            streak_q   <= 3'd0;
            ownerMem_q <= 1'b0;
            mRen_q     <= 1'b0;
            mWen_q     <= 1'b0;
            mAddr_q    <= '0;
            mWdata_q   <= '0;
            mWstrb_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            ownerMem_q <= ownerMem_d;
            mRen_q     <= mRen_d;
            mWen_q     <= mWen_d;
            mAddr_q    <= mAddr_d;
            mWdata_q   <= mWdata_d;
            mWstrb_q   <= mWstrb_d;
            rdata_q    <= rdata_d;
        end
    end

    // Output pulses decoded from state; forced low while reset is asserted.
    always_comb begin
        o_if_addr_ok  = ifGrant && !i_areset;
        o_mem_addr_ok = memGrant && !i_areset;
        o_m_valid     = (state_q == ST_ISSUE) && !i_areset;
        o_if_data_ok  = (state_q == ST_RESP) && !ownerMem_q && !i_areset;
        o_mem_data_ok = (state_q == ST_RESP) && ownerMem_q && !i_areset;
        o_if_rdata    = rdata_q;
        o_mem_rdata   = rdata_q;
        o_m_ren       = mRen_q;
        o_m_wen       = mWen_q;
        o_m_addr      = mAddr_q;
        o_m_wdata     = mWdata_q;
        o_m_wstrb     = mWstrb_q;
    end

endmodule

// File: tb/tb_axil_rw_arbiter.sv
// Directed self-checking bench for axil_rw_arbiter. Inputs change 1ns after
// each rising edge; outputs are checked 2ns after the edge.
module tb_axil_rw_arbiter;

    logic        clk;
    logic        areset;
    logic        ifValid;
    logic [31:0] ifAddr;
    logic        ifAddrOk, ifDataOk;
    logic [63:0] ifRdata;
    logic        memValid, memRen, memWen;
    logic [31:0] memAddr;
    logic [63:0] memWdata;
    logic [7:0]  memWstrb;
    logic        memAddrOk, memDataOk;
    logic [63:0] memRdata;
    logic        mValid, mRen, mWen;
    logic [31:0] mAddr;
    logic [63:0] mWdata;
    logic [7:0]  mWstrb;
    logic        mAddrOk, mDataOk;
    logic [63:0] mRdata;

    int checks = 0;
    int errors = 0;

    axil_rw_arbiter #(
        .DATA_WIDTH    (64),
        .ADDR_WIDTH    (32),
        .STRB_WIDTH    (8),
        .MEM_STREAK_MAX(4)
    ) dut (
        .i_aclk       (clk),
        .i_areset     (areset),
        .i_if_valid   (ifValid),
        .i_if_addr    (ifAddr),
        .o_if_addr_ok (ifAddrOk),
        .o_if_data_ok (ifDataOk),
        .o_if_rdata   (ifRdata),
        .i_mem_valid  (memValid),
        .i_mem_ren    (memRen),
        .i_mem_wen    (memWen),
        .i_mem_addr   (memAddr),
        .i_mem_wdata  (memWdata),
        .i_mem_wstrb  (memWstrb),
        .o_mem_addr_ok(memAddrOk),
        .o_mem_data_ok(memDataOk),
        .o_mem_rdata  (memRdata),
        .o_m_valid    (mValid),
        .o_m_ren      (mRen),
        .o_m_wen      (mWen),
        .o_m_addr     (mAddr),
        .o_m_wdata    (mWdata),
        .o_m_wstrb    (mWstrb),
        .i_m_addr_ok  (mAddrOk),
        .i_m_data_ok  (mDataOk),
        .i_m_rdata    (mRdata)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ifV, input logic [31:0] ifA,
                                 input logic memV, input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb, input logic dOk,
                                 input logic [63:0] rdata);
        ifValid  = ifV;
        ifAddr   = ifA;
        memValid = memV;
        memRen   = ren;
        memWen   = wen;
        memAddr  = addr;
        memWdata = wdata;
        memWstrb = wstrb;
        mDataOk  = dOk;
        mRdata   = rdata;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 64'h0);
    endtask

    initial begin
        logic grantIsIf [10];
        int   nGrants;

        areset  = 1'b1;
        mAddrOk = 1'b0;
        applyIdle();
        nextCycle();
        nextCycle();
        $display("[TB] reset state");
        checkOutput("rstMValid",  mValid,  1'b0);
        checkOutput("rstMAddr",   mAddr,   32'h0);
        checkOutput("rstIfData",  ifDataOk, 1'b0);
        checkOutput("rstIfRdata", ifRdata, 64'h0);

        // ---------------- single IF read ----------------
        $display("[TB] single IF read");
        nextCycle();
        areset = 1'b0;
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 64'h0);
        checkOutput("if1AddrOk",  ifAddrOk,  1'b1);
        checkOutput("if1MemAok",  memAddrOk, 1'b0);
        checkOutput("if1ValidC0", mValid,    1'b0);
        nextCycle();
        applyIdle();
        checkOutput("if1ValidC1", mValid, 1'b1);
        checkOutput("if1Ren",     mRen,   1'b1);
        checkOutput("if1Wen",     mWen,   1'b0);
        checkOutput("if1Addr",    mAddr,  32'h8000_0000);
        checkOutput("if1Wstrb",   mWstrb, 8'h0);
        checkOutput("if1Wdata",   mWdata, 64'h0);
        nextCycle();
        applyIdle();
        checkOutput("if1ValidC2", mValid,   1'b0);
        checkOutput("if1AokC2",   ifAddrOk, 1'b0);
        nextCycle();
        applyIdle();
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h1122_3344_5566_7788);
        checkOutput("if1DokC4", ifDataOk, 1'b0);
        nextCycle();
        applyIdle();
        checkOutput("if1DokC5",  ifDataOk,  1'b1);
        checkOutput("if1Rdata",  ifRdata,   64'h1122_3344_5566_7788);
        checkOutput("if1MemDok", memDataOk, 1'b0);
        nextCycle();
        applyIdle();
        checkOutput("if1DokC6", ifDataOk, 1'b0);

        // ---------------- MEM write ----------------
        $display("[TB] MEM write");
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 64'hDEAD_BEEF, 8'h0F, 1'b0, 64'h0);
        checkOutput("wrMemAok", memAddrOk, 1'b1);
        checkOutput("wrIfAok",  ifAddrOk,  1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 64'h0);
        checkOutput("wrValid", mValid, 1'b1);
        checkOutput("wrWen",   mWen,   1'b1);
        checkOutput("wrRen",   mRen,   1'b0);
        checkOutput("wrAddr",  mAddr,  32'h8000_0100);
        checkOutput("wrWdata", mWdata, 64'hDEAD_BEEF);
        checkOutput("wrWstrb", mWstrb, 8'h0F);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyIdle();
            checkOutput($sformatf("wrWaitValid%0d", i), mValid, 1'b0);
            checkOutput($sformatf("wrWaitAddr%0d", i),  mAddr,  32'h8000_0100);
            checkOutput($sformatf("wrWaitWdata%0d", i), mWdata, 64'hDEAD_BEEF);
            checkOutput($sformatf("wrWaitWstrb%0d", i), mWstrb, 8'h0F);
        end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
        checkOutput("wrDokEarly", memDataOk, 1'b0);
        nextCycle();
        applyIdle();
        checkOutput("wrMemDok", memDataOk, 1'b1);
        checkOutput("wrRdata",  memRdata,  64'h0);
        checkOutput("wrIfDok",  ifDataOk,  1'b0);

        // ---------------- null MEM request ----------------
        $display("[TB] null MEM request");
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8000_0200, 64'h0, 8'h0, 1'b0, 64'h0);
        checkOutput("nullMemAok", memAddrOk, 1'b1);
        checkOutput("nullValid0", mValid,    1'b0);
        nextCycle();
        applyIdle();
        checkOutput("nullMemDok", memDataOk, 1'b1);
        checkOutput("nullRdata",  memRdata,  64'h0);
        checkOutput("nullValid1", mValid,    1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h9999);
        checkOutput("nullDokGone", memDataOk, 1'b0);
        checkOutput("nullValid2",  mValid,    1'b0);
        nextCycle();
        applyIdle();
        checkOutput("spurMemDok", memDataOk, 1'b0);
        checkOutput("spurIfDok",  ifDataOk,  1'b0);
        checkOutput("spurValid",  mValid,    1'b0);

        // ---------------- ren and wen both set ----------------
        $display("[TB] MEM ren+wen");
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_0300, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'h0);
        checkOutput("rwMemAok", memAddrOk, 1'b1);
        nextCycle();
        applyIdle();
        checkOutput("rwValid", mValid, 1'b1);
        checkOutput("rwWen",   mWen,   1'b1);
        checkOutput("rwRen",   mRen,   1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h5555_5555_5555_5555);
        nextCycle();
        applyIdle();
        checkOutput("rwMemDok", memDataOk, 1'b1);
        checkOutput("rwRdata",  memRdata,  64'h0);

        // ---------------- starvation guard ----------------
        $display("[TB] starvation guard");
        nGrants = 0;
        for (int c = 0; c < 80 && nGrants < 10; c++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h8000_1000, 1'b1, 1'b0, 1'b0, 32'h8000_2000, 64'h0, 8'h0, 1'b1, 64'h77);
            if (ifAddrOk && memAddrOk) begin
                checkOutput("dualAddrOk", 1'b1, 1'b0);
            end
            if (ifAddrOk || memAddrOk) begin
                grantIsIf[nGrants] = ifAddrOk;
                nGrants++;
            end
        end
        checkOutput("starveGrantCount", 64'(nGrants), 64'd10);
        for (int i = 0; i < nGrants; i++) begin
            checkOutput($sformatf("starveGrant%0d", i), grantIsIf[i], (i == 4 || i == 9) ? 1'b1 : 1'b0);
        end
        // Drain the final IF grant: ISSUE, WAIT, RESP
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h77);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h77);
        nextCycle();
        applyIdle();
        checkOutput("starveIfDok",   ifDataOk, 1'b1);
        checkOutput("starveIfRdata", ifRdata,  64'h77);

        // ---------------- reset mid-operation ----------------
        $display("[TB] reset in WAIT");
        nextCycle();
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 64'h0);
        checkOutput("rstOpAok", ifAddrOk, 1'b1);
        nextCycle();
        applyIdle();
        checkOutput("rstOpValid", mValid, 1'b1);
        nextCycle();
        areset = 1'b1;
        applyIdle();
        nextCycle();
        areset = 1'b0;
        applyIdle();
        checkOutput("rstOpMValid", mValid,   1'b0);
        checkOutput("rstOpMRen",   mRen,     1'b0);
        checkOutput("rstOpMAddr",  mAddr,    32'h0);
        checkOutput("rstOpIfDok",  ifDataOk, 1'b0);
        checkOutput("rstOpRdata",  ifRdata,  64'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'hDEAD);
        nextCycle();
        applyIdle();
        checkOutput("rstLateIfDok",  ifDataOk,  1'b0);
        checkOutput("rstLateMemDok", memDataOk, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'h8000_0080, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0, 64'h0);
        checkOutput("postRstAok", ifAddrOk, 1'b1);
        nextCycle();
        applyIdle();
        checkOutput("postRstValid", mValid, 1'b1);
        checkOutput("postRstAddr",  mAddr,  32'h8000_0080);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1, 64'h0BAD_F00D_CAFE_1234);
        nextCycle();
        applyIdle();
        checkOutput("postRstDok",   ifDataOk, 1'b1);
        checkOutput("postRstRdata", ifRdata,  64'h0BAD_F00D_CAFE_1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
